led_sequencer: RTL

Parametrised LED pattern generator for the board top level. It merges the rate counter and the LED shift register into one block. The block adds a switch-selectable tick rate, an enable, four pattern modes (rotate left, rotate right, ping-pong, hold) and routing of the pattern to the red, green and blue LED banks. It is driven directly by board switches and drives the LED outputs.

---
 rtl/led_seq_pkg.sv | 20 ++
 rtl/led_prescaler.sv | 52 +++++
 rtl/led_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: switch modes, colour bank selects
// and ping-pong sweep direction.
package led_seq_pkg;

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam logic [1:0] COL_R   = 2'b00;
  localparam logic [1:0] COL_G   = 2'b01;
  localparam logic [1:0] COL_B   = 2'b10;
  localparam logic [1:0] COL_ALL = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned N_BANKS = 3;

endpackage

// File: rtl/led_prescaler.sv
// Rate prescaler: free-running counter that emits a one-cycle tick when it
// reaches the terminal count chosen by the rate switches.
module led_prescaler #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned LIMIT_0   = 2**23 - 1,
  parameter int unsigned LIMIT_1   = 2**24 - 1,
  parameter int unsigned LIMIT_2   = 2**25 - 1,
  parameter int unsigned LIMIT_3   = 2**26 - 1
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_rate,
  output logic       o_tick
);

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] limit_sel;
  logic                 tick_reg;

  always_comb begin
    limit_sel = CNT_WIDTH'(LIMIT_3);
    case (i_rate)
      2'd0:    limit_sel = CNT_WIDTH'(LIMIT_0);
      2'd1:    limit_sel = CNT_WIDTH'(LIMIT_1);
      2'd2:    limit_sel = CNT_WIDTH'(LIMIT_2);
      default: limit_sel = CNT_WIDTH'(LIMIT_3);
    endcase
  end

  // >= rather than == so a lower rate selected mid-count ticks at once
  // instead of wrapping the whole counter.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (i_enable) begin
      if (cnt_reg >= limit_sel) begin
        cnt_reg  <= '0;
        tick_reg <= 1'b1;
      end else begin
        cnt_reg  <= cnt_reg + 1'b1;
        tick_reg <= 1'b0;
      end
    end else begin
      tick_reg <= 1'b0;
    end
  end

  assign o_tick = tick_reg;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern generator: prescaled tick steps a one-hot pattern (rotate,
// ping-pong or hold) that is routed to the selected colour bank(s).
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned N_LEDS    = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned LIMIT_0   = 2**23 - 1,
  parameter int unsigned LIMIT_1   = 2**24 - 1,
  parameter int unsigned LIMIT_2   = 2**25 - 1,
  parameter int unsigned LIMIT_3   = 2**26 - 1
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [1:0]        i_rate,
  input  logic [1:0]        i_mode,
  input  logic [1:0]        i_color,
  output logic [N_LEDS-1:0] o_led_r,
  output logic [N_LEDS-1:0] o_led_g,
  output logic [N_LEDS-1:0] o_led_b,
  output logic              o_tick
);

  logic                          tick;
  logic [N_LEDS-1:0]             pattern_reg, pattern_next;
  logic                          dir_reg, dir_next;
  logic [N_BANKS-1:0][N_LEDS-1:0] led_reg, led_next;

  led_prescaler #(
    .CNT_WIDTH (CNT_WIDTH),
    .LIMIT_0   (LIMIT_0),
    .LIMIT_1   (LIMIT_1),
    .LIMIT_2   (LIMIT_2),
    .LIMIT_3   (LIMIT_3)
  ) u_prescaler (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_rate   (i_rate),
    .o_tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (i_reset) begin
      pattern_reg <= N_LEDS'(1);
      dir_reg     <= DIR_LEFT;
    end else begin
      pattern_reg <= pattern_next;
      dir_reg     <= dir_next;
    end
  end

  // The registered tick is the step strobe, so the pattern moves one cycle
  // after the tick pulse is first visible.
  always_comb begin
    pattern_next = pattern_reg;
    dir_next     = dir_reg;
    if (tick) begin
      case (i_mode)
        MODE_LEFT:  pattern_next = {pattern_reg[N_LEDS-2:0], pattern_reg[N_LEDS-1]};
        MODE_RIGHT: pattern_next = {pattern_reg[0], pattern_reg[N_LEDS-1:1]};
        MODE_PING: begin
          if (dir_reg == DIR_LEFT && pattern_reg[N_LEDS-1]) begin
            dir_next     = DIR_RIGHT;
            pattern_next = pattern_reg >> 1;
          end else if (dir_reg == DIR_RIGHT && pattern_reg[0]) begin
            dir_next     = DIR_LEFT;
            pattern_next = pattern_reg << 1;
          end else if (dir_reg == DIR_LEFT) begin
            pattern_next = pattern_reg << 1;
          end else begin
            pattern_next = pattern_reg >> 1;
          end
        end
        default: pattern_next = pattern_reg;
      endcase
    end
  end

  // Bank index matches the colour code: 0 red, 1 green, 2 blue.
  for (genvar gi = 0; gi < N_BANKS; gi++) begin : gen_bank
    assign led_next[gi] = (i_color == 2'(gi) || i_color == COL_ALL) ? pattern_reg : '0;
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      led_reg <= '0;
    end else begin
      led_reg <= led_next;
    end
  end

  assign o_led_r = led_reg[0];
  assign o_led_g = led_reg[1];
  assign o_led_b = led_reg[2];
  assign o_tick  = tick;

endmodule
